adc_frame_packer: RTL
=====================

// Module: adc_frame_packer
// PURPOSE
// Downstream stage of the AD9643 DDR capture block, in the m_axi_aclk domain.
// - Pairs the 16-bit chA/chB sample streams into 32-bit words {chB, chA}.
// - Buffers the words in a first-word-fall-through FIFO.
// - Emits fixed-length frames on an AXI-Stream master, with tlast on the final word, for the DMA.
// PARAMETERS
// FIFO_AW    4   FIFO address width; depth = 2**FIFO_AW words
// LEN_WIDTH  16  width of capture_len and the internal word counter
// PORTS
// m_axi_aclk      in   1          sample clock; sole clock of the block
// m_axi_areset    in   1          reset, synchronous, active-high
// s_tvalid_chA    in   1          chA sample valid (one-cycle strobe)
// s_tdata_chA     in   16         chA sample, zero-extended by upstream
// s_tvalid_chB    in   1          chB sample valid; arrives 0..1 cycle after chA
// s_tdata_chB     in   16         chB sample
// s_tready        out  1          to upstream m_axi_tready
// capture_start   in   1          one-cycle pulse; starts a frame
// capture_len     in   LEN_WIDTH  words per frame; latched on the accepted start
// m_axis_tvalid   out  1          output word valid
// m_axis_tdata    out  32         {chB[15:0], chA[15:0]}
// m_axis_tlast    out  1          marks the final word of the frame
// m_axis_tready   in   1          downstream ready
// busy            out  1          high in CAPTURE or DRAIN
// overflow        out  1          sticky; a pair was dropped because the FIFO was full
// pair_err_cnt    out  8          saturating count of unpaired samples
// BEHAVIOUR
// Reset:
// - All outputs are 0. FIFO is empty. FSM is in IDLE.
// - The A-holding register is cleared and the word counter is 0.
// - Reset asserted mid-frame discards the partial frame. No tlast is emitted for it.
// FSM states: IDLE, CAPTURE, DRAIN.
// - IDLE -> CAPTURE on capture_start with capture_len != 0.
//   - On that transition: latch len, clear counter, clear overflow, clear pair_err_cnt.
//   - capture_start with len == 0 is ignored.
// - CAPTURE -> DRAIN on the edge where the word that makes count == len is written.
// - DRAIN -> IDLE on the edge where the last FIFO word pops (tlast handshake).
// - capture_start in CAPTURE or DRAIN is ignored.
// s_tready: 1 only in CAPTURE with at least 2 free FIFO entries; else 0.
// Pairing, active in CAPTURE only; samples arriving outside CAPTURE are ignored:
// - chA valid: store the sample in the A-holding register and set a_pend.
// - chA valid while a_pend is already set: the old A is replaced and pair_err_cnt += 1.
// - chB valid with a_pend set: form word {B, held A}.
//   - Push on the same edge and clear a_pend.
// - chA and chB valid in the same cycle with a_pend set:
//   - Pair B with the held A.
//   - The new A becomes held and a_pend stays 1.
// - chA and chB valid in the same cycle with a_pend clear:
//   - Pair B with the incoming A directly.
// - chB valid with no A available: drop B and pair_err_cnt += 1.
// - pair_err_cnt saturates at 255.
// FIFO:
// - Push is rejected when count == depth, judged before any same-cycle pop.
// - A rejected push sets overflow and is not counted toward len.
// - Pop occurs on m_axis_tvalid & m_axis_tready.
// - m_axis_tvalid = FIFO not empty. tdata and tlast are held stable while tvalid & ~tready.
// - Latency: a word pushed at edge N is visible on m_axis_* in cycle N+1.
// - tlast is stored per entry. It is set only on the word whose push made count == len.
// Counter:
// - LEN_WIDTH bits; counts accepted pushes only.
// - capture_len of all-ones is a valid maximum length; no wrap occurs before the compare.
// TESTING
// - len=4; A/B pairs with B one cycle after A, tready=1:
//   - 4 words {B,A} come out with tlast on word 4, then busy falls to 0.
// - len=3; chA/chB simultaneous, values A=16'h0011, B=16'h0022:
//   - tdata=32'h0022_0011 at 1-cycle latency; pair_err_cnt=0.
// - FIFO_AW=2, len=10, tready=0:
//   - s_tready drops at 3 words and FIFO fills to 4.
//   - Forced extra pairs set overflow=1; the count excludes the dropped pairs.
// - Two chA strobes without chB, then a lone chB, then chB: pair_err_cnt=2.
//   - The next pair uses the second A.
// - tready toggled 1/0 every cycle during len=8: all 8 words are in order and stable while stalled.
// - Reset asserted mid-frame:
//   - Outputs go to 0 next cycle and the FSM returns to IDLE.
//   - capture_start with len=0 afterwards leaves busy=0.

Source files
------------

// File: rtl/adc_frame_packer.sv
// Pairs chA/chB ADC samples into {chB, chA} words, buffers them in a FWFT FIFO
// and emits fixed-length AXI-Stream frames with tlast on the final word.
module adc_frame_packer #(
  parameter int FIFO_AW   = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_areset,
  input  logic                 s_tvalid_chA,
  input  logic [15:0]          s_tdata_chA,
  input  logic                 s_tvalid_chB,
  input  logic [15:0]          s_tdata_chB,
  output logic                 s_tready,
  input  logic                 capture_start,
  input  logic [LEN_WIDTH-1:0] capture_len,
  output logic                 m_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 overflow,
  output logic [7:0]           pair_err_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t               state_q;
  logic [32:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [FIFO_AW:0]     fill_q;
  logic [15:0]          a_hold_q;
  logic                 a_pend_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] word_cnt_q;
  logic                 overflow_q;
  logic [7:0]           pair_err_q;

  logic                 capturing;
  logic                 full;
  logic                 not_empty;
  logic                 pair_fire;
  logic                 push;
  logic                 pop;
  logic                 last_word;
  logic                 err_inc;
  logic                 a_pend_d;
  logic [15:0]          a_hold_d;
  logic [15:0]          pair_a;
  logic [LEN_WIDTH-1:0] word_cnt_d;
  logic [FIFO_AW:0]     free_slots;

  // Pairing decisions and FIFO handshake for the current cycle.
  always_comb begin
    capturing  = (state_q == ST_CAPTURE);
    full       = (fill_q == DEPTH_C);
    not_empty  = (fill_q != (FIFO_AW + 1)'(0));
    free_slots = DEPTH_C - fill_q;
    pair_a     = a_pend_q ? a_hold_q : s_tdata_chA;
    pair_fire  = capturing & s_tvalid_chB & (a_pend_q | s_tvalid_chA);
    push       = pair_fire & ~full;
    pop        = not_empty & m_axis_tready;
    word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
    last_word  = (word_cnt_d == len_q);
    err_inc    = capturing &
                 ((s_tvalid_chA & ~s_tvalid_chB & a_pend_q) |
                  (s_tvalid_chB & ~s_tvalid_chA & ~a_pend_q));
    a_pend_d   = a_pend_q;
    a_hold_d   = a_hold_q;
    // A new A is held unless it is consumed directly by a same-cycle B.
    if (s_tvalid_chA & (~s_tvalid_chB | a_pend_q)) begin
      a_pend_d = 1'b1;
      a_hold_d = s_tdata_chA;
    end else if (s_tvalid_chB) begin
      a_pend_d = 1'b0;
    end else begin
      a_pend_d = a_pend_q;
    end
  end

  // FIFO storage; the tlast flag travels with each word.
  always_ff @(posedge m_axi_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {last_word, s_tdata_chB, pair_a};
    end
  end

  // Frame FSM, FIFO pointers, pairing state and status counters.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      a_hold_q   <= 16'd0;
      a_pend_q   <= 1'b0;
      len_q      <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      pair_err_q <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + (FIFO_AW + 1)'(1);
        2'b01:   fill_q <= fill_q - (FIFO_AW + 1)'(1);
        default: fill_q <= fill_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (capture_start && (capture_len != '0)) begin
            state_q    <= ST_CAPTURE;
            len_q      <= capture_len;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
            pair_err_q <= 8'd0;
            a_pend_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          a_pend_q <= a_pend_d;
          a_hold_q <= a_hold_d;
          if (err_inc && (pair_err_q != 8'hFF)) pair_err_q <= pair_err_q + 8'd1;
          if (pair_fire && full) overflow_q <= 1'b1;
          if (push) begin
            word_cnt_q <= word_cnt_d;
            if (last_word) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && mem_q[rd_ptr_q][32]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_tready      = capturing && (free_slots >= (FIFO_AW + 1)'(2));
  assign m_axis_tvalid = not_empty;
  assign m_axis_tdata  = not_empty ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign m_axis_tlast  = not_empty ? mem_q[rd_ptr_q][32] : 1'b0;
  assign busy          = (state_q != ST_IDLE);
  assign overflow      = overflow_q;
  assign pair_err_cnt  = pair_err_q;

endmodule
